// File: rtl/imem_boot_pkg.sv
// Shared definitions for the instruction-memory boot sequencer.
//   boot_state_e : sequencer FSM states (3-bit encoding)
//   PC_SEL_INW   : instruction_unit PC mux select that loads PC from PC_InW
//   WORD_SHIFT   : word index to byte address shift (4-byte words)
package imem_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLR_PC    = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_WRITE     = 3'd3,
    ST_SET_START = 3'd4,
    ST_DONE      = 3'd5
  } boot_state_e;

  localparam logic [1:0]  PC_SEL_INW = 2'b10;
  localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/imem_boot_sequencer.sv
// Boot sequencer in front of instruction_unit; sole driver of its control pins.
// Boot mode streams words (valid/ready) into instruction memory from address 0,
// then loads PC with START_ADDR and pulses done. In IDLE the control-unit
// requests pass straight through with zero latency.
// Ports:
//   clk, reset_n              : clock (rising edge), async active-low reset
//   boot_start, ld_count      : load request and word count (1..WORDS_MAX)
//   ld_data/ld_valid/ld_ready : word stream handshake
//   cu_*                      : control-unit requests (honoured only in IDLE)
//   pc_ld..ir_ld, pc_sel,
//   PC_InW, D_In              : instruction_unit control/data
//   busy, cpu_hold            : sequencer active / control-unit stall
//   done, err                 : completion / rejected-request pulses
//   word_cnt                  : words written in the current load
module imem_boot_sequencer
  import imem_boot_pkg::*;
#(
  parameter int          WORDS_MAX  = 1024,
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter int          CNT_W      = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             boot_start,
  input  logic [CNT_W-1:0] ld_count,
  input  logic [31:0]      ld_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic             cu_pc_ld,
  input  logic             cu_pc_inc,
  input  logic             cu_j_flg,
  input  logic             cu_im_cs,
  input  logic             cu_im_wr,
  input  logic             cu_im_rd,
  input  logic             cu_ir_ld,
  input  logic [1:0]       cu_pc_sel,
  input  logic [31:0]      cu_pc_inw,
  output logic             pc_ld,
  output logic             pc_inc,
  output logic             j_flg,
  output logic             im_cs,
  output logic             im_wr,
  output logic             im_rd,
  output logic             ir_ld,
  output logic [1:0]       pc_sel,
  output logic [31:0]      PC_InW,
  output logic [31:0]      D_In,
  output logic             busy,
  output logic             cpu_hold,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] word_cnt
);

  boot_state_e      state;
  logic [CNT_W-1:0] len_reg;
  logic [31:0]      data_reg;
  logic [CNT_W-1:0] word_cnt_nxt;
  logic             len_ok;

  assign word_cnt_nxt = word_cnt + CNT_W'(1);
  assign len_ok       = (ld_count != '0) && (ld_count <= CNT_W'(WORDS_MAX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      len_reg  <= '0;
      data_reg <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (boot_start) begin
            if (len_ok) begin
              len_reg  <= ld_count;
              word_cnt <= '0;
              state    <= ST_CLR_PC;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_CLR_PC: state <= ST_WAIT_DATA;
        ST_WAIT_DATA: begin
          if (ld_valid) begin
            data_reg <= ld_data;
            state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          word_cnt <= word_cnt_nxt;
          state    <= (word_cnt_nxt == len_reg) ? ST_SET_START : ST_WAIT_DATA;
        end
        ST_SET_START: begin
          done  <= 1'b1;  // registered so it is high exactly during DONE
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output mux: IDLE passes control-unit requests through, other states drive
  // their own strobes. Everything toward instruction_unit is gated by reset_n.
  always_comb begin
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    j_flg    = 1'b0;
    im_cs    = 1'b0;
    im_wr    = 1'b0;
    im_rd    = 1'b0;
    ir_ld    = 1'b0;
    pc_sel   = 2'b00;
    PC_InW   = '0;
    D_In     = '0;
    ld_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        pc_ld  = cu_pc_ld;
        pc_inc = cu_pc_inc;
        j_flg  = cu_j_flg;
        im_cs  = cu_im_cs;
        im_wr  = cu_im_wr;
        im_rd  = cu_im_rd;
        ir_ld  = cu_ir_ld;
        pc_sel = cu_pc_sel;
        PC_InW = cu_pc_inw;
      end
      ST_CLR_PC: begin
        pc_ld  = 1'b1;
        pc_sel = PC_SEL_INW;
      end
      ST_WAIT_DATA: ld_ready = 1'b1;
      ST_WRITE: begin
        im_cs  = 1'b1;
        im_wr  = 1'b1;
        pc_inc = 1'b1;
        D_In   = data_reg;
      end
      ST_SET_START: begin
        pc_ld  = 1'b1;
        pc_sel = PC_SEL_INW;
        PC_InW = START_ADDR;
      end
      default: ;
    endcase
    if (!reset_n) begin
      pc_ld    = 1'b0;
      pc_inc   = 1'b0;
      j_flg    = 1'b0;
      im_cs    = 1'b0;
      im_wr    = 1'b0;
      im_rd    = 1'b0;
      ir_ld    = 1'b0;
      pc_sel   = 2'b00;
      PC_InW   = '0;
      D_In     = '0;
      ld_ready = 1'b0;
    end
  end

  assign busy     = (state != ST_IDLE);
  assign cpu_hold = busy | ~reset_n;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Directed bench for imem_boot_sequencer with a small instruction_unit stand-in
// (12-bit PC, byte memory, IR) used to check addresses and stored words.
module tb_imem_boot_sequencer;
  import imem_boot_pkg::*;

  localparam int CNT_W = 11;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             boot_start;
  logic [CNT_W-1:0] ld_count;
  logic [31:0]      ld_data;
  logic             ld_valid;
  logic             ld_ready;
  logic             cu_pc_ld, cu_pc_inc, cu_j_flg, cu_im_cs, cu_im_wr, cu_im_rd, cu_ir_ld;
  logic [1:0]       cu_pc_sel;
  logic [31:0]      cu_pc_inw;
  logic             pc_ld, pc_inc, j_flg, im_cs, im_wr, im_rd, ir_ld;
  logic [1:0]       pc_sel;
  logic [31:0]      PC_InW, D_In;
  logic             busy, cpu_hold, done, err;
  logic [CNT_W-1:0] word_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_boot_sequencer #(
    .WORDS_MAX (1024),
    .START_ADDR(32'h0000_0000),
    .CNT_W     (CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .boot_start(boot_start), .ld_count(ld_count),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .cu_pc_ld(cu_pc_ld), .cu_pc_inc(cu_pc_inc), .cu_j_flg(cu_j_flg),
    .cu_im_cs(cu_im_cs), .cu_im_wr(cu_im_wr), .cu_im_rd(cu_im_rd),
    .cu_ir_ld(cu_ir_ld), .cu_pc_sel(cu_pc_sel), .cu_pc_inw(cu_pc_inw),
    .pc_ld(pc_ld), .pc_inc(pc_inc), .j_flg(j_flg), .im_cs(im_cs),
    .im_wr(im_wr), .im_rd(im_rd), .ir_ld(ir_ld), .pc_sel(pc_sel),
    .PC_InW(PC_InW), .D_In(D_In), .busy(busy), .cpu_hold(cpu_hold),
    .done(done), .err(err), .word_cnt(word_cnt)
  );

  // instruction_unit stand-in: big-endian 4-byte write at PC, PC+=4 on inc
  logic [7:0]  mem [0:4095];
  logic [11:0] pc_m;
  logic [31:0] ir_m;

  always @(posedge clk) begin
    if (im_cs && im_wr) begin
      mem[pc_m]         <= D_In[31:24];
      mem[pc_m + 12'd1] <= D_In[23:16];
      mem[pc_m + 12'd2] <= D_In[15:8];
      mem[pc_m + 12'd3] <= D_In[7:0];
    end
    if (im_cs && im_rd && ir_ld)
      ir_m <= {mem[pc_m], mem[pc_m + 12'd1], mem[pc_m + 12'd2], mem[pc_m + 12'd3]};
    if (!reset_n)
      pc_m <= 12'd0;
    else if (pc_ld && pc_sel == PC_SEL_INW)
      pc_m <= PC_InW[11:0];
    else if (pc_inc)
      pc_m <= pc_m + 12'd4;
  end

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {mem[a], mem[a + 12'd1], mem[a + 12'd2], mem[a + 12'd3]};
  endfunction

  function automatic logic [31:0] word_of(input int k);
    case (k)
      0:       return 32'h2008_0005;
      1:       return 32'h2009_0003;
      2:       return 32'h0109_5020;
      default: return 32'hA500_0000 ^ 32'(k);
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int err_seen;

  // Runs one load. stall_idx/stall_len hold ld_valid low for that many
  // WAIT_DATA cycles before word stall_idx; inj_cyc pulses boot_start and
  // cu_pc_ld in that cycle after the request.
  task automatic run_load(input int n, input int stall_idx, input int stall_len,
                          input int inj_cyc, output int done_cyc, output int n_pcld);
    int acc = 0, stalled = 0, wr = 0;
    int limit = 2 * n + stall_len + 20;
    logic valid, accept;
    done_cyc = -1;
    n_pcld   = 0;
    ld_count   = CNT_W'(n);
    boot_start = 1'b1;
    ld_valid   = 1'b0;
    step();
    boot_start = 1'b0;
    for (int c = 1; c <= limit && done_cyc < 0; c++) begin
      valid    = !(acc == stall_idx && stalled < stall_len);
      ld_valid = valid;
      ld_data  = word_of(acc);
      if (c == inj_cyc) begin
        boot_start = 1'b1;
        ld_count   = CNT_W'(2);
        cu_pc_ld   = 1'b1;
        cu_pc_sel  = PC_SEL_INW;
        cu_pc_inw  = 32'h0000_0100;
      end
      #1;
      if (im_wr) begin
        check_val("wr_pc", {20'd0, pc_m}, 32'(wr) << WORD_SHIFT);
        check_val("wr_data", D_In, word_of(wr));
        wr++;
      end
      if (!valid && ld_ready) begin
        stalled++;
        check_val("stall_no_wr", {31'd0, im_wr}, 32'd0);
      end
      if (pc_ld) n_pcld++;
      if (err) err_seen++;
      if (done) done_cyc = c;
      accept = ld_ready && ld_valid;
      step();
      boot_start = 1'b0;
      cu_pc_ld   = 1'b0;
      cu_pc_sel  = 2'b00;
      cu_pc_inw  = '0;
      if (accept) acc++;
    end
    ld_valid = 1'b0;
    if (done_cyc < 0) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  int dc, npl, wr5;

  initial begin
    reset_n = 1'b0; boot_start = 1'b0; ld_count = '0; ld_data = '0; ld_valid = 1'b0;
    cu_pc_ld = 1'b0; cu_pc_inc = 1'b0; cu_j_flg = 1'b0; cu_im_cs = 1'b1;
    cu_im_wr = 1'b0; cu_im_rd = 1'b1; cu_ir_ld = 1'b1; cu_pc_sel = 2'b00;
    cu_pc_inw = 32'h0000_0abc;
    err_seen = 0;

    // 1: reset gating and IDLE pass-through
    step(); step();
    check_val("rst_im_cs", {31'd0, im_cs}, 32'd0);
    check_val("rst_im_rd", {31'd0, im_rd}, 32'd0);
    check_val("rst_ir_ld", {31'd0, ir_ld}, 32'd0);
    check_val("rst_pc_inw", PC_InW, 32'd0);
    check_val("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_ready", {31'd0, ld_ready}, 32'd0);
    check_val("rst_cnt", 32'(word_cnt), 32'd0);
    reset_n = 1'b1;
    #1;
    check_val("idle_im_cs", {31'd0, im_cs}, 32'd1);
    check_val("idle_im_rd", {31'd0, im_rd}, 32'd1);
    check_val("idle_ir_ld", {31'd0, ir_ld}, 32'd1);
    check_val("idle_pc_inw", PC_InW, 32'h0000_0abc);
    check_val("idle_hold", {31'd0, cpu_hold}, 32'd0);
    cu_im_rd = 1'b0;
    #1;
    check_val("idle_im_rd_0lat", {31'd0, im_rd}, 32'd0);
    cu_im_cs = 1'b0; cu_ir_ld = 1'b0; cu_pc_inw = '0;
    step();

    // 2: three-word load, then fetch through control-unit path
    run_load(3, -1, 0, 0, dc, npl);
    check_val("t2_done_cyc", 32'(dc), 32'd9);
    check_val("t2_pc_loads", 32'(npl), 32'd2);
    check_val("t2_word_cnt", 32'(word_cnt), 32'd3);
    check_val("t2_pc_start", {20'd0, pc_m}, 32'd0);
    check_val("t2_mem8", mem_word(12'd8), 32'h0109_5020);
    check_val("t2_busy_after", {31'd0, busy}, 32'd0);
    cu_im_cs = 1'b1; cu_im_rd = 1'b1; cu_ir_ld = 1'b1;
    step();
    cu_im_cs = 1'b0; cu_im_rd = 1'b0; cu_ir_ld = 1'b0;
    check_val("t2_ir", ir_m, 32'h2008_0005);

    // 3: five-cycle stall before the second word
    run_load(3, 1, 5, 0, dc, npl);
    check_val("t3_done_cyc", 32'(dc), 32'd14);
    check_val("t3_word_cnt", 32'(word_cnt), 32'd3);

    // 4: rejected lengths
    foreach (ld_count[i]) ;
    for (int k = 0; k < 2; k++) begin
      ld_count   = (k == 0) ? CNT_W'(0) : CNT_W'(1025);
      boot_start = 1'b1;
      step();
      boot_start = 1'b0;
      check_val("t4_err", {31'd0, err}, 32'd1);
      check_val("t4_busy", {31'd0, busy}, 32'd0);
      step();
      check_val("t4_err_pulse", {31'd0, err}, 32'd0);
      check_val("t4_idle", {31'd0, busy}, 32'd0);
    end

    // 6: boot_start and cu_pc_ld during a load are ignored
    err_seen = 0;
    run_load(3, -1, 0, 3, dc, npl);
    check_val("t6_done_cyc", 32'(dc), 32'd9);
    check_val("t6_pc_loads", 32'(npl), 32'd2);
    check_val("t6_word_cnt", 32'(word_cnt), 32'd3);
    check_val("t6_no_err", 32'(err_seen), 32'd0);

    // Full-size load: PC wraps at the end, START_ADDR still wins
    run_load(1024, -1, 0, 0, dc, npl);
    check_val("max_done_cyc", 32'(dc), 32'd2051);
    check_val("max_word_cnt", 32'(word_cnt), 32'd1024);
    check_val("max_pc", {20'd0, pc_m}, 32'd0);
    check_val("max_mem_last", mem_word(12'd4092), word_of(1023));

    // 5: reset in the WAIT_DATA cycle after the 2nd write of a 4-word load
    wr5 = 0;
    ld_count = CNT_W'(4); boot_start = 1'b1; ld_valid = 1'b1;
    begin : t5_load
      int acc5 = 0;
      step();
      boot_start = 1'b0;
      for (int c = 0; c < 20 && wr5 < 2; c++) begin
        ld_data = word_of(acc5 + 100);
        #1;
        if (ld_ready) acc5++;
        if (im_wr) wr5++;
        step();
      end
    end
    check_val("t5_writes", 32'(wr5), 32'd2);
    check_val("t5_pre_ready", {31'd0, ld_ready}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("t5_ready_0", {31'd0, ld_ready}, 32'd0);
    check_val("t5_hold", {31'd0, cpu_hold}, 32'd1);
    check_val("t5_busy", {31'd0, busy}, 32'd0);
    check_val("t5_cnt_async", 32'(word_cnt), 32'd0);
    step();
    reset_n = 1'b1;
    begin : t5_after
      int dones = 0;
      for (int c = 0; c < 12; c++) begin
        step();
        if (done) dones++;
      end
      check_val("t5_no_done", 32'(dones), 32'd0);
    end
    check_val("t5_idle", {31'd0, busy}, 32'd0);
    check_val("t5_cnt", 32'(word_cnt), 32'd0);
    check_val("t5_mem_kept", mem_word(12'd4), word_of(101));
    ld_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
